// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus signal bundle between a single initiator and the interconnect.
// The master modport drives address/control/write data; the slave modport returns the response.
interface ahb_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HMASTLOCK;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator turning core load/store requests into SINGLE/NONSEQ transfers.
// Optional hung-slave timeout is enabled by defining AHB_MASTER_TIMEOUT_EN.
module ahb_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  ahb_lite_master_if.master     ahb
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  state_t                state_reg, state_next;
  logic                  req_ready_reg, req_ready_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic                  rsp_err_reg, rsp_err_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [1:0]            htrans_reg, htrans_next;
  logic [ADDR_WIDTH-1:0] haddr_reg, haddr_next;
  logic                  hwrite_reg, hwrite_next;
  logic [2:0]            hsize_reg, hsize_next;
  logic [DATA_WIDTH-1:0] hwdata_reg, hwdata_next;
  logic                  illegal_reg, illegal_next;
  logic                  accept;
  logic                  req_legal;
  logic                  timeout_hit;

  assign accept = req_valid && req_ready_reg;

  always_comb begin
    req_legal = 1'b0;
    case (req_size)
      3'd0:    req_legal = 1'b1;
      3'd1:    req_legal = (req_addr[0] == 1'b0);
      3'd2:    req_legal = (req_addr[1:0] == 2'b00);
      default: req_legal = 1'b0;
    endcase
  end

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             bus_wait;

  assign bus_wait    = ((state_reg == S_ADDR && !illegal_reg) || state_reg == S_DATA) && !ahb.HREADY;
  assign timeout_hit = bus_wait && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == S_IDLE || timeout_hit) begin
      wait_cnt_reg <= '0;
    end else if (bus_wait) begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Illegal requests pass through ADDR without driving the bus, so the error response
  // lands two cycles after acceptance while HTRANS stays IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = S_ADDR;
      S_ADDR: begin
        if (illegal_reg || timeout_hit) state_next = S_RESP;
        else if (ahb.HREADY)            state_next = S_DATA;
      end
      S_DATA: if (timeout_hit || ahb.HREADY) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_next = (state_next == S_IDLE);
    rsp_valid_next = (state_next == S_RESP);
    rsp_err_next   = rsp_err_reg;
    rsp_rdata_next = rsp_rdata_reg;
    htrans_next    = TR_IDLE;
    haddr_next     = haddr_reg;
    hwrite_next    = hwrite_reg;
    hsize_next     = hsize_reg;
    hwdata_next    = hwdata_reg;
    illegal_next   = illegal_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          illegal_next = !req_legal;
          if (req_legal) begin
            htrans_next = TR_NONSEQ;
            haddr_next  = req_addr;
            hwrite_next = req_write;
            hsize_next  = req_size;
            hwdata_next = req_wdata;
          end
        end
      end
      S_ADDR: begin
        if (state_next == S_ADDR) htrans_next = TR_NONSEQ;
        if (illegal_reg || timeout_hit) rsp_err_next = 1'b1;
      end
      S_DATA: begin
        if (timeout_hit) begin
          rsp_err_next = 1'b1;
        end else if (ahb.HREADY) begin
          rsp_err_next = ahb.HRESP;
          if (!ahb.HRESP && !hwrite_reg) rsp_rdata_next = ahb.HRDATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      htrans_reg    <= TR_IDLE;
      haddr_reg     <= '0;
      hwrite_reg    <= 1'b0;
      hsize_reg     <= 3'd0;
      hwdata_reg    <= '0;
      illegal_reg   <= 1'b0;
    end else begin
      req_ready_reg <= req_ready_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
      htrans_reg    <= htrans_next;
      haddr_reg     <= haddr_next;
      hwrite_reg    <= hwrite_next;
      hsize_reg     <= hsize_next;
      hwdata_reg    <= hwdata_next;
      illegal_reg   <= illegal_next;
    end
  end

  assign req_ready     = req_ready_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_err       = rsp_err_reg;
  assign rsp_rdata     = rsp_rdata_reg;
  assign ahb.HTRANS    = htrans_reg;
  assign ahb.HADDR     = haddr_reg;
  assign ahb.HWRITE    = hwrite_reg;
  assign ahb.HSIZE     = hsize_reg;
  assign ahb.HWDATA    = hwdata_reg;
  assign ahb.HBURST    = 3'b000;
  assign ahb.HPROT     = 4'b0011;
  assign ahb.HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: reactive AHB slave plus a transaction-level reference model.
// Also exercises the AHB_MASTER_TIMEOUT_EN build when that macro is defined.
module tb_ahb_lite_master;

  logic        HCLK, HRESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  ahb_lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ahb(bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int          tests_run;
  int          tests_failed;
  logic [31:0] model_rdata;

  // Observations of the most recent transaction
  int          o_idle, o_lat, o_nonseq, o_data;
  logic        o_addr_ok, o_wdata_ok, o_rsp, o_err, o_overlap, o_clean;
  logic [31:0] o_rdata;

  function automatic logic is_legal(input logic [31:0] a, input logic [2:0] s);
    return (s <= 3'd2) && ((a % (32'd1 << s)) == 32'd0);
  endfunction

  // Presents one request and plays the slave: aw address-phase waits, w data-phase waits,
  // optional two-cycle ERROR ending. Stops on rsp_valid or after budget cycles.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                         input logic [31:0] wd, input int aw, input int w, input logic err_resp,
                         input logic [31:0] rd, input int budget);
    int   aw_left, w_left;
    logic in_data;
    o_idle = 0; o_lat = 0; o_nonseq = 0; o_data = 0;
    o_addr_ok = 1'b1; o_wdata_ok = 1'b1; o_rsp = 1'b0; o_err = 1'b0;
    o_rdata = '0; o_overlap = 1'b0;
    @(negedge HCLK);
    o_clean = (rsp_valid === 1'b0);
    while (req_ready !== 1'b1 && o_idle < 20) begin
      o_idle++;
      @(negedge HCLK);
    end
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_size = sz; req_wdata = wd;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    aw_left = aw; w_left = w; in_data = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge HCLK);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      req_write = 1'($urandom); req_size = 3'($urandom);
      if (rsp_valid === 1'b1) begin
        o_rsp = 1'b1; o_lat = k; o_err = rsp_err; o_rdata = rsp_rdata;
        o_overlap = (req_ready === 1'b1);
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        break;
      end
      bus.HRDATA = $urandom;
      if (in_data) begin
        o_data++;
        if (bus.HWDATA !== wd) o_wdata_ok = 1'b0;
        if (w_left > 0) begin
          bus.HREADY = 1'b0;
          bus.HRESP  = err_resp && (w_left == 1);
          w_left--;
        end else begin
          bus.HREADY = 1'b1;
          bus.HRESP  = err_resp;
          bus.HRDATA = err_resp ? ~rd : rd;
          in_data    = 1'b0;
        end
      end else if (bus.HTRANS === 2'b10) begin
        o_nonseq++;
        if (bus.HADDR !== addr || bus.HWRITE !== wr || bus.HSIZE !== sz) o_addr_ok = 1'b0;
        bus.HRESP = 1'b0;
        if (aw_left > 0) begin
          bus.HREADY = 1'b0;
          aw_left--;
        end else begin
          bus.HREADY = 1'b1;
          in_data = 1'b1;
        end
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end
    end
    $display("[TB] txn addr=%h wr=%0d sz=%0d aw=%0d w=%0d err=%0d -> rsp=%0d lat=%0d rsp_err=%0d rdata=%h",
             addr, wr, sz, aw, w, err_resp, o_rsp, o_lat, o_err, o_rdata);
  endtask

  task automatic test_reset;
    HRESETn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = '0; req_wdata = '0;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
    model_rdata = '0;
    #12;
    tests_run++;
    if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
      tests_failed++; $display("FAIL reset_handshake: got %b expected 100", {req_ready, rsp_valid, rsp_err});
    end
    tests_run++;
    if (rsp_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata);
    end
    tests_run++;
    if ({bus.HTRANS, bus.HWRITE, bus.HSIZE} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b expected 000000", {bus.HTRANS, bus.HWRITE, bus.HSIZE});
    end
    tests_run++;
    if (bus.HADDR !== 32'h0 || bus.HWDATA !== 32'h0) begin
      tests_failed++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", bus.HADDR, bus.HWDATA);
    end
    tests_run++;
    if ({bus.HBURST, bus.HPROT, bus.HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
      tests_failed++; $display("FAIL reset_consts: got %b expected 00000110", {bus.HBURST, bus.HPROT, bus.HMASTLOCK});
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  task automatic test_word_read;
    run_txn(32'h0200_0004, 1'b0, 3'd2, 32'h1111_2222, 0, 0, 1'b0, 32'hDEAD_BEEF, 50);
    model_rdata = 32'hDEAD_BEEF;
    tests_run++;
    if (o_lat !== 3) begin tests_failed++; $display("FAIL word_read_lat: got %0d expected 3", o_lat); end
    tests_run++;
    if (o_nonseq !== 1 || o_addr_ok !== 1'b1) begin
      tests_failed++; $display("FAIL word_read_addr_phase: nonseq=%0d ok=%0d expected 1/1", o_nonseq, o_addr_ok);
    end
    tests_run++;
    if (o_rdata !== 32'hDEAD_BEEF || o_err !== 1'b0) begin
      tests_failed++; $display("FAIL word_read_rsp: got %h err=%0d expected deadbeef err=0", o_rdata, o_err);
    end
  endtask

  task automatic test_byte_write;
    run_txn(32'h1001_3003, 1'b1, 3'd0, 32'h5A00_0000, 0, 3, 1'b0, 32'hCAFE_F00D, 50);
    tests_run++;
    if (o_lat !== 6) begin tests_failed++; $display("FAIL byte_write_lat: got %0d expected 6", o_lat); end
    tests_run++;
    if (o_data !== 4 || o_wdata_ok !== 1'b1) begin
      tests_failed++; $display("FAIL byte_write_wdata: cycles=%0d held=%0d expected 4/1", o_data, o_wdata_ok);
    end
    tests_run++;
    if (o_addr_ok !== 1'b1 || o_rdata !== model_rdata || o_err !== 1'b0) begin
      tests_failed++; $display("FAIL byte_write_rsp: ok=%0d rdata=%h err=%0d expected 1/%h/0", o_addr_ok, o_rdata, o_err, model_rdata);
    end
  endtask

  task automatic test_error_read;
    run_txn(32'h0000_1000, 1'b0, 3'd2, 32'h0, 0, 1, 1'b1, 32'h1234_5678, 50);
    tests_run++;
    if (o_err !== 1'b1 || o_rdata !== model_rdata) begin
      tests_failed++; $display("FAIL error_read_rsp: err=%0d rdata=%h expected 1/%h", o_err, o_rdata, model_rdata);
    end
    tests_run++;
    if (o_lat !== 4) begin tests_failed++; $display("FAIL error_read_lat: got %0d expected 4", o_lat); end
    run_txn(32'h0000_2000, 1'b0, 3'd1, 32'h0, 0, 0, 1'b0, 32'h0000_ABCD, 50);
    model_rdata = 32'h0000_ABCD;
    tests_run++;
    if (o_idle !== 0 || o_clean !== 1'b1) begin
      tests_failed++; $display("FAIL error_next_accept: idle=%0d clean=%0d expected 0/1", o_idle, o_clean);
    end
    tests_run++;
    if (o_rdata !== model_rdata || o_lat !== 3) begin
      tests_failed++; $display("FAIL error_next_rsp: rdata=%h lat=%0d expected %h/3", o_rdata, o_lat, model_rdata);
    end
  endtask

  task automatic test_illegal;
    logic [2:0] sizes [2];
    logic [31:0] addrs [2];
    sizes[0] = 3'd2; addrs[0] = 32'h0000_0002;
    sizes[1] = 3'd3; addrs[1] = 32'h0000_0100;
    for (int i = 0; i < 2; i++) begin
      run_txn(addrs[i], 1'b0, sizes[i], 32'h0, 0, 0, 1'b0, 32'hFFFF_0000, 50);
      tests_run++;
      if (o_nonseq !== 0) begin tests_failed++; $display("FAIL illegal_htrans[%0d]: nonseq=%0d expected 0", i, o_nonseq); end
      tests_run++;
      if (o_lat !== 2 || o_err !== 1'b1 || o_rdata !== model_rdata) begin
        tests_failed++; $display("FAIL illegal_rsp[%0d]: lat=%0d err=%0d rdata=%h expected 2/1/%h", i, o_lat, o_err, o_rdata, model_rdata);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd, exp_rdata;
    logic [2:0]  sz;
    logic        wr, e, legal;
    int          aw, w, exp_lat;
    for (int i = 0; i < 40; i++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      wr = 1'($urandom); wd = $urandom; rd = $urandom;
      aw = $urandom_range(0, 2); w = $urandom_range(0, 3);
      e  = (w > 0) && ($urandom_range(0, 4) == 0);
      legal     = is_legal(a, sz);
      exp_lat   = legal ? 3 + aw + w : 2;
      exp_rdata = (legal && !wr && !e) ? rd : model_rdata;
      run_txn(a, wr, sz, wd, aw, w, e, rd, 50);
      model_rdata = exp_rdata;
      tests_run++;
      if (o_rsp !== 1'b1 || o_lat !== exp_lat) begin
        tests_failed++; $display("FAIL rand_lat[%0d]: rsp=%0d lat=%0d expected 1/%0d", i, o_rsp, o_lat, exp_lat);
      end
      tests_run++;
      if (o_err !== (!legal || e)) begin
        tests_failed++; $display("FAIL rand_err[%0d]: got %0d expected %0d", i, o_err, (!legal || e));
      end
      tests_run++;
      if (o_rdata !== exp_rdata) begin
        tests_failed++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, o_rdata, exp_rdata);
      end
      tests_run++;
      if (o_nonseq !== (legal ? aw + 1 : 0) || o_data !== (legal ? w + 1 : 0)) begin
        tests_failed++; $display("FAIL rand_phases[%0d]: nonseq=%0d data=%0d expected %0d/%0d",
                                 i, o_nonseq, o_data, legal ? aw + 1 : 0, legal ? w + 1 : 0);
      end
      tests_run++;
      if (o_addr_ok !== 1'b1 || o_wdata_ok !== 1'b1) begin
        tests_failed++; $display("FAIL rand_bus_stable[%0d]: addr_ok=%0d wdata_ok=%0d expected 1/1", i, o_addr_ok, o_wdata_ok);
      end
      tests_run++;
      if (o_idle !== 0 || o_overlap !== 1'b0 || o_clean !== 1'b1) begin
        tests_failed++; $display("FAIL rand_back_to_back[%0d]: idle=%0d overlap=%0d clean=%0d expected 0/0/1",
                                 i, o_idle, o_overlap, o_clean);
      end
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    run_txn(32'h0000_0040, 1'b0, 3'd2, 32'h0, 0, 1000, 1'b0, 32'h0, 3);
    tests_run++;
    if (o_rsp !== 1'b0 || req_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_setup: rsp=%0d ready=%0d expected 0/0", o_rsp, req_ready);
    end
    #2 HRESETn = 1'b0;
    #1;
    tests_run++;
    if (bus.HTRANS !== 2'b00 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_async: htrans=%b ready=%0d rsp=%0d expected 00/1/0", bus.HTRANS, req_ready, rsp_valid);
    end
    @(negedge HCLK);
    HRESETn = 1'b1; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    model_rdata = '0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (rsp_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL reset_mid_no_rsp: pulses=%0d expected 0", pulses); end
    run_txn(32'h0000_0044, 1'b0, 3'd2, 32'h0, 0, 0, 1'b0, 32'h0BAD_F00D, 50);
    model_rdata = 32'h0BAD_F00D;
    tests_run++;
    if (o_lat !== 3 || o_rdata !== model_rdata) begin
      tests_failed++; $display("FAIL reset_mid_recover: lat=%0d rdata=%h expected 3/%h", o_lat, o_rdata, model_rdata);
    end
  endtask

  task automatic test_hang;
`ifdef AHB_MASTER_TIMEOUT_EN
    run_txn(32'h0000_0080, 1'b0, 3'd2, 32'h0, 0, 100000, 1'b0, 32'h0, 50);
    tests_run++;
    if (o_rsp !== 1'b1 || o_lat !== 6 || o_err !== 1'b1) begin
      tests_failed++; $display("FAIL timeout_rsp: rsp=%0d lat=%0d err=%0d expected 1/6/1", o_rsp, o_lat, o_err);
    end
    tests_run++;
    if (o_rdata !== model_rdata) begin tests_failed++; $display("FAIL timeout_rdata: got %h expected %h", o_rdata, model_rdata); end
`else
    run_txn(32'h0000_0080, 1'b0, 3'd2, 32'h0, 0, 100000, 1'b0, 32'h0, 1000);
    tests_run++;
    if (o_rsp !== 1'b0) begin tests_failed++; $display("FAIL no_timeout: rsp=%0d lat=%0d expected no response", o_rsp, o_lat); end
    tests_run++;
    if (o_data < 990 || o_wdata_ok !== 1'b1) begin
      tests_failed++; $display("FAIL no_timeout_wait: data_cycles=%0d held=%0d expected >=990/1", o_data, o_wdata_ok);
    end
`endif
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_word_read();
    test_byte_write();
    test_error_read();
    test_illegal();
    test_random();
    test_reset_mid();
    test_hang();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
